// File: rtl/hazard_stall_controller.sv
// Hazard stall controller for a 5-stage pipeline.
// Covers the hazards operand forwarding cannot resolve: load-use stalls,
// taken-branch flushes and a whole-pipeline freeze while data memory is
// busy (with a watchdog that latches a sticky fault). Also keeps
// saturating stall/flush event counters for performance debug.
//
// Control outputs are combinational from the current state and inputs.
// State and counters update on the rising clock edge. state_dbg exposes
// the FSM state (0 = RUN, 1 = MEM_WAIT, 2 = FAULT) for checkers.
module hazard_stall_controller #(
    parameter int MEM_TIMEOUT = 64,
    parameter int WAIT_W      = 8,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       rs1_id,
    input  logic [4:0]       rs2_id,
    input  logic             uses_rs1_id,
    input  logic             uses_rs2_id,
    input  logic [4:0]       rd_ex,
    input  logic             MemRead_ex,
    input  logic             branch_taken_ex,
    input  logic             dmem_req_mem,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             pipe_freeze,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FAULT    = 2'd2
    } state_t;

    localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(MEM_TIMEOUT);

    state_t             state_q;
    logic [WAIT_W-1:0]  wait_q;
    logic [WAIT_W-1:0]  wait_d;
    logic [CNT_W-1:0]   stall_q;
    logic [CNT_W-1:0]   flush_q;
    logic               timeout_q;

    logic mem_wait;
    logic load_use;
    logic freeze_c;
    logic flush_ev;
    logic stall_ev;

    // Hazard detection and the action chosen this cycle, before reset gating.
    always_comb begin
        mem_wait = dmem_req_mem & ~dmem_ready;
        load_use = MemRead_ex & (rd_ex != 5'd0) &
                   ((uses_rs1_id & (rd_ex == rs1_id)) |
                    (uses_rs2_id & (rd_ex == rs2_id)));
        wait_d   = wait_q + WAIT_W'(1);
        freeze_c = 1'b0;
        flush_ev = 1'b0;
        stall_ev = 1'b0;
        // FAULT freezes unconditionally; otherwise a memory wait wins and
        // holds any branch or load-use until the freeze releases. A branch
        // flushes the ID instruction, so a simultaneous load-use is moot.
        if (state_q == FAULT || mem_wait) begin
            freeze_c = 1'b1;
        end else if (branch_taken_ex) begin
            flush_ev = 1'b1;
        end else if (load_use) begin
            stall_ev = 1'b1;
        end
    end

    // Pipeline control outputs; reset forces the default (running) values.
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        pipe_freeze = 1'b0;
        if (rst_n) begin
            if (freeze_c) begin
                pipe_freeze = 1'b1;
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
            end else if (flush_ev) begin
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
            end else if (stall_ev) begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_flush  = 1'b1;
            end
        end
    end

    // FSM, wait watchdog and saturating event counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RUN;
            wait_q    <= '0;
            stall_q   <= '0;
            flush_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            case (state_q)
                FAULT: begin
                    // Sticky until reset; memory readiness is ignored.
                    timeout_q <= 1'b1;
                end
                default: begin
                    if (mem_wait) begin
                        wait_q <= wait_d;
                        if (state_q == MEM_WAIT && wait_d == TIMEOUT_V) begin
                            state_q   <= FAULT;
                            timeout_q <= 1'b1;
                        end else begin
                            state_q <= MEM_WAIT;
                        end
                    end else begin
                        state_q <= RUN;
                        wait_q  <= '0;
                        if (flush_ev && flush_q != '1) begin
                            flush_q <= flush_q + CNT_W'(1);
                        end
                        if (stall_ev && stall_q != '1) begin
                            stall_q <= stall_q + CNT_W'(1);
                        end
                    end
                end
            endcase
        end
    end

    assign mem_timeout = timeout_q;
    assign stall_count = stall_q;
    assign flush_count = flush_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Bench for hazard_stall_controller: directed vectors with hand-computed
// literal checks, plus a behavioural model checked on every falling edge.
module tb_hazard_stall_controller;

    localparam int MT   = 4;
    localparam int CW   = 2;
    localparam int CMAX = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [4:0]    rs1_id, rs2_id, rd_ex;
    logic          uses_rs1_id, uses_rs2_id, MemRead_ex, branch_taken_ex;
    logic          dmem_req_mem, dmem_ready;
    logic          pc_write, ifid_write, ifid_flush, idex_flush, pipe_freeze;
    logic          mem_timeout;
    logic [CW-1:0] stall_count, flush_count;
    logic [1:0]    state_dbg;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: mode 0 = running, 1 = waiting on memory, 2 = faulted.
    int m_mode, m_wait, m_stalls, m_flushes, m_to;
    int e_pc, e_ifw, e_iff, e_idf, e_frz, ev_flush, ev_stall;
    bit mw, lu;

    hazard_stall_controller #(.MEM_TIMEOUT(MT), .WAIT_W(8), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs1_id(rs1_id), .rs2_id(rs2_id),
        .uses_rs1_id(uses_rs1_id), .uses_rs2_id(uses_rs2_id),
        .rd_ex(rd_ex), .MemRead_ex(MemRead_ex),
        .branch_taken_ex(branch_taken_ex),
        .dmem_req_mem(dmem_req_mem), .dmem_ready(dmem_ready),
        .pc_write(pc_write), .ifid_write(ifid_write),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .pipe_freeze(pipe_freeze), .mem_timeout(mem_timeout),
        .stall_count(stall_count), .flush_count(flush_count),
        .state_dbg(state_dbg)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model + per-cycle compare on the falling edge (inputs stable here).
    always @(negedge clk) begin
        if (!rst_n) begin
            m_mode = 0; m_wait = 0; m_stalls = 0; m_flushes = 0; m_to = 0;
        end
        e_pc = 1; e_ifw = 1; e_iff = 0; e_idf = 0; e_frz = 0;
        ev_flush = 0; ev_stall = 0;
        mw = dmem_req_mem && !dmem_ready;
        lu = MemRead_ex && rd_ex != 0 &&
             ((uses_rs1_id && rd_ex == rs1_id) || (uses_rs2_id && rd_ex == rs2_id));
        if (rst_n) begin
            if (m_mode == 2 || mw) begin
                e_frz = 1; e_pc = 0; e_ifw = 0;
            end else if (branch_taken_ex) begin
                e_iff = 1; e_idf = 1; ev_flush = 1;
            end else if (lu) begin
                e_pc = 0; e_ifw = 0; e_idf = 1; ev_stall = 1;
            end
        end
        chk("m_pc_write",    32'(pc_write),    32'(e_pc));
        chk("m_ifid_write",  32'(ifid_write),  32'(e_ifw));
        chk("m_ifid_flush",  32'(ifid_flush),  32'(e_iff));
        chk("m_idex_flush",  32'(idex_flush),  32'(e_idf));
        chk("m_pipe_freeze", 32'(pipe_freeze), 32'(e_frz));
        chk("m_mem_timeout", 32'(mem_timeout), 32'(m_to));
        chk("m_stall_count", 32'(stall_count), 32'(m_stalls));
        chk("m_flush_count", 32'(flush_count), 32'(m_flushes));
        chk("m_state",       32'(state_dbg),   32'(m_mode));
        if (rst_n) begin
            if (ev_flush) m_flushes = (m_flushes < CMAX) ? m_flushes + 1 : CMAX;
            if (ev_stall) m_stalls  = (m_stalls  < CMAX) ? m_stalls  + 1 : CMAX;
            if (m_mode != 2) begin
                if (mw) begin
                    m_wait = m_wait + 1;
                    if (m_wait == MT) begin
                        m_mode = 2; m_to = 1;
                    end else begin
                        m_mode = 1;
                    end
                end else begin
                    m_mode = 0; m_wait = 0;
                end
            end
        end
    end

    // Driver tasks
    task automatic set_in(input logic [4:0] r1, input logic [4:0] r2,
                          input logic u1, input logic u2, input logic [4:0] rd,
                          input logic mr, input logic br, input logic req, input logic rdy);
        rs1_id = r1; rs2_id = r2; uses_rs1_id = u1; uses_rs2_id = u2;
        rd_ex = rd; MemRead_ex = mr; branch_taken_ex = br;
        dmem_req_mem = req; dmem_ready = rdy;
    endtask

    task automatic idle();
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic to_neg();
        @(negedge clk); #1;
    endtask

    task automatic to_next();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        to_next();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        // Memory wait asserted during reset: outputs must still be defaults.
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        to_next();
        chk("rst_pc_write",    32'(pc_write),    32'd1);
        chk("rst_ifid_write",  32'(ifid_write),  32'd1);
        chk("rst_ifid_flush",  32'(ifid_flush),  32'd0);
        chk("rst_pipe_freeze", 32'(pipe_freeze), 32'd0);
        chk("rst_counts",      32'({stall_count, flush_count}), 32'd0);
        chk("rst_state",       32'(state_dbg),   32'd0);
        idle();
        to_next();
        rst_n = 1'b1;

        // Load-use on rs1 stalls one cycle.
        set_in(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        to_neg();
        chk("lu_pc_write",   32'(pc_write),   32'd0);
        chk("lu_ifid_write", 32'(ifid_write), 32'd0);
        chk("lu_idex_flush", 32'(idex_flush), 32'd1);
        to_next();
        idle(); to_neg();
        chk("lu_stall_count", 32'(stall_count), 32'd1);
        to_next();
        // Same registers but rs1 not used: no stall.
        set_in(5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        to_neg();
        chk("nolu_idex_flush", 32'(idex_flush), 32'd0);
        chk("nolu_pc_write",   32'(pc_write),   32'd1);
        to_next();
        // Load-use through rs2.
        set_in(5'd0, 5'd7, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        to_neg();
        chk("lu2_idex_flush", 32'(idex_flush), 32'd1);
        to_next();
        idle(); to_neg();
        chk("lu2_stall_count", 32'(stall_count), 32'd2);
        to_next();

        // Branch together with load-use: flush wins, no stall counted.
        do_reset();
        set_in(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
        to_neg();
        chk("br_ifid_flush", 32'(ifid_flush), 32'd1);
        chk("br_idex_flush", 32'(idex_flush), 32'd1);
        chk("br_pc_write",   32'(pc_write),   32'd1);
        to_next();
        // rd_ex = 0 matching rs1 = 0 never stalls.
        set_in(5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        to_neg();
        chk("br_flush_count", 32'(flush_count), 32'd1);
        chk("br_stall_count", 32'(stall_count), 32'd0);
        chk("r0_idex_flush",  32'(idex_flush),  32'd0);
        to_next();

        // Memory wait for 3 cycles then ready.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
            to_neg();
            chk("mw_freeze", 32'(pipe_freeze), 32'd1);
            chk("mw_pc",     32'(pc_write),    32'd0);
            to_next();
        end
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        to_neg();
        chk("mw_rel_freeze", 32'(pipe_freeze), 32'd0);
        chk("mw_rel_state",  32'(state_dbg),   32'd1);
        to_next();
        idle(); to_neg();
        chk("mw_back_run", 32'(state_dbg), 32'd0);
        to_next();

        // Taken branch held through a wait, acted on at release.
        do_reset();
        for (int i = 0; i < 2; i++) begin
            set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
            to_neg();
            chk("wb_no_flush", 32'(ifid_flush), 32'd0);
            to_next();
        end
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        to_neg();
        chk("wb_rel_flush",  32'(ifid_flush),  32'd1);
        chk("wb_rel_freeze", 32'(pipe_freeze), 32'd0);
        to_next();
        idle(); to_neg();
        chk("wb_flush_count", 32'(flush_count), 32'd1);
        to_next();

        // Timeout after MT wait cycles, then async reset clears the fault.
        do_reset();
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        to_next();
        for (int i = 0; i < MT; i++) begin
            set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
            to_neg();
            chk("to_not_yet", 32'(mem_timeout), 32'd0);
            to_next();
        end
        to_neg();
        chk("to_fault",       32'(mem_timeout), 32'd1);
        chk("to_fault_state", 32'(state_dbg),   32'd2);
        to_next();
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        to_neg();
        chk("to_hold_freeze", 32'(pipe_freeze), 32'd1);
        chk("to_hold_noflush", 32'(ifid_flush), 32'd0);
        to_next();
        #2;
        rst_n = 1'b0;
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        #1;
        chk("ar_mem_timeout", 32'(mem_timeout), 32'd0);
        chk("ar_freeze",      32'(pipe_freeze), 32'd0);
        chk("ar_pc_write",    32'(pc_write),    32'd1);
        chk("ar_flush_count", 32'(flush_count), 32'd0);
        chk("ar_state",       32'(state_dbg),   32'd0);
        idle();
        to_next();
        rst_n = 1'b1;

        // Saturation: 5 load-use events on a 2-bit counter.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_in(5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
            to_next();
        end
        idle(); to_neg();
        chk("sat_stall_count", 32'(stall_count), 32'd3);
        to_next();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
